// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants and FSM state types for the 8N1 UART link.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   UART_DATA_BITS       = 8;
    localparam logic UART_IDLE            = 1'b1;
    localparam int   UART_DEFAULT_CLK_DIV = 434;   // 50 MHz / 115200 baud

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    // One spare bit keeps CLK_DIV itself representable at the top of the range.
    function automatic int uart_timer_width(input int clk_div);
        return $clog2(clk_div) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Loadable down-counter; done pulses once when the count expires.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_active;

    // Loading N makes done fire N+1 cycles later; a reload wins over expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_count  <= load_val;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - c_one;
            end
        end
    end

    assign done = r_active && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_link.sv
`default_nettype none
// ============================================================================
// Module   : uart_link
// Purpose  : Full-duplex 8N1 UART transceiver between the RN41 and wireless.
// Revision : 1.0 - initial release
// ============================================================================
module uart_link
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      tx,
    input  logic                      transmit,
    input  logic [UART_DATA_BITS-1:0] tx_byte,
    output logic                      received,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      is_receiving,
    output logic                      is_transmitting,
    output logic                      recv_error
);

    localparam int c_timer_w = uart_timer_width(CLK_DIV);
    localparam int c_idx_w   = $clog2(UART_DATA_BITS);

    localparam logic [c_timer_w-1:0] c_bit_load  = c_timer_w'(CLK_DIV - 1);
    localparam logic [c_timer_w-1:0] c_half_load = c_timer_w'(CLK_DIV / 2 - 1);
    localparam logic [c_idx_w-1:0]   c_last_bit  = c_idx_w'(UART_DATA_BITS - 1);
    localparam logic [c_idx_w-1:0]   c_idx_one   = c_idx_w'(1);

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    tx_state_t                 r_tx_state, w_tx_state_nxt;
    logic [UART_DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [c_idx_w-1:0]        r_tx_idx,   w_tx_idx_nxt;
    logic                      r_tx,       w_tx_nxt;
    logic                      w_tx_load;
    logic                      w_tx_done;

    uart_bit_timer #(.WIDTH(c_timer_w)) u_tx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tx_load),
        .load_val (c_bit_load),
        .done     (w_tx_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            r_tx       <= UART_IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_nxt       = r_tx;
        w_tx_load      = 1'b0;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (transmit) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = tx_byte;
                    w_tx_nxt       = ~UART_IDLE;
                    w_tx_load      = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_done) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_nxt       = r_tx_shift[0];
                    w_tx_shift_nxt = {1'b0, r_tx_shift[UART_DATA_BITS-1:1]};
                    w_tx_idx_nxt   = '0;
                    w_tx_load      = 1'b1;
                end
            end
            TX_DATA: begin
                if (w_tx_done) begin
                    w_tx_load = 1'b1;
                    if (r_tx_idx == c_last_bit) begin
                        w_tx_state_nxt = TX_STOP;
                        w_tx_nxt       = UART_IDLE;
                    end else begin
                        w_tx_nxt       = r_tx_shift[0];
                        w_tx_shift_nxt = {1'b0, r_tx_shift[UART_DATA_BITS-1:1]};
                        w_tx_idx_nxt   = r_tx_idx + c_idx_one;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_done) begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    assign tx              = r_tx;
    assign is_transmitting = (r_tx_state != TX_IDLE);

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    logic r_rx_meta, r_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= UART_IDLE;
            r_rx_s    <= UART_IDLE;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    rx_state_t                 r_rx_state, w_rx_state_nxt;
    logic [UART_DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic [UART_DATA_BITS-1:0] r_rx_byte,  w_rx_byte_nxt;
    logic [c_idx_w-1:0]        r_rx_idx,   w_rx_idx_nxt;
    logic                      r_received, w_received_nxt;
    logic                      r_recv_err, w_recv_err_nxt;
    logic                      w_rx_load;
    logic [c_timer_w-1:0]      w_rx_load_val;
    logic                      w_rx_done;

    uart_bit_timer #(.WIDTH(c_timer_w)) u_rx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_rx_load),
        .load_val (w_rx_load_val),
        .done     (w_rx_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_idx   <= '0;
            r_received <= 1'b0;
            r_recv_err <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_byte  <= w_rx_byte_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_received <= w_received_nxt;
            r_recv_err <= w_recv_err_nxt;
        end
    end

    // The half-bit start delay puts every later sample near mid-bit.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_byte_nxt  = r_rx_byte;
        w_rx_idx_nxt   = r_rx_idx;
        w_received_nxt = 1'b0;
        w_recv_err_nxt = 1'b0;
        w_rx_load      = 1'b0;
        w_rx_load_val  = c_bit_load;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_s != UART_IDLE) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_load      = 1'b1;
                    w_rx_load_val  = c_half_load;
                end
            end
            RX_START: begin
                if (w_rx_done) begin
                    if (r_rx_s == UART_IDLE) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_DATA;
                        w_rx_idx_nxt   = '0;
                        w_rx_load      = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_done) begin
                    w_rx_shift_nxt = {r_rx_s, r_rx_shift[UART_DATA_BITS-1:1]};
                    w_rx_load      = 1'b1;
                    if (r_rx_idx == c_last_bit) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + c_idx_one;
                    end
                end
            end
            RX_STOP: begin
                if (w_rx_done) begin
                    if (r_rx_s == UART_IDLE) begin
                        w_rx_byte_nxt  = r_rx_shift;
                        w_received_nxt = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_recv_err_nxt = 1'b1;
                        w_rx_state_nxt = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (r_rx_s == UART_IDLE) begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    assign received     = r_received;
    assign recv_error   = r_recv_err;
    assign rx_byte      = r_rx_byte;
    assign is_receiving = (r_rx_state != RX_IDLE);

endmodule
`default_nettype wire
